// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_pkg
// Brief    : Shared types and helpers for the register-file dump engine:
//            sequencer state encoding, channel/index width helpers and the
//            rotate-left used by the optional checksum beat
//            (REGFILE_DUMP_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

  // Sequencer states: run phase, read-address phase, beat-offer phase.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_RD   = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } dump_state_e;

  // Widest register the rotate helper handles; XLEN must not exceed it.
  localparam int ROL_MAX_W = 64;

  // Channel-select width; a single channel still gets one select bit.
  function automatic int cw_f(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  // Register-index width.
  function automatic int iw_f(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Rotate the low w bits of v left by one; bits above w must be zero on
  // entry and are zero on return. w is a constant at every call site.
  function automatic logic [ROL_MAX_W-1:0] rol1(input logic [ROL_MAX_W-1:0] v,
                                                input int                  w);
    logic [ROL_MAX_W-1:0] mask;
    mask = (w >= ROL_MAX_W) ? '1 : ((ROL_MAX_W'(1) << w) - ROL_MAX_W'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl_if
// Brief    : Bus bundle of the dump engine: debug read port towards the
//            register files and the valid/ready beat stream towards the sink.
//            master = dump engine, slave = register files + sink.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_dump_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NCHAN = 2
);
  import regfile_dump_pkg::*;

  localparam int CW = cw_f(NCHAN);
  localparam int IW = iw_f(NREGS);

  // Debug read port (synchronous read, one cycle latency)
  logic [CW-1:0]   dbg_rchan;
  logic [IW-1:0]   dbg_raddr;
  logic [XLEN-1:0] dbg_rdata;

  // Dump beat stream
  logic            dump_valid;
  logic            dump_ready;
  logic [XLEN-1:0] dump_data;
  logic [CW-1:0]   dump_chan;
  logic [IW-1:0]   dump_idx;
  logic            dump_last;

  modport master (
    output dbg_rchan, dbg_raddr,
    input  dbg_rdata,
    output dump_valid, dump_data, dump_chan, dump_idx, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dbg_rchan, dbg_raddr,
    output dbg_rdata,
    input  dump_valid, dump_data, dump_chan, dump_idx, dump_last,
    output dump_ready
  );

endinterface
`default_nettype wire

// File: rtl/dump_beat_reg.sv
`default_nettype none
// ============================================================================
// Module   : dump_beat_reg
// Brief    : Output holding register for a valid/ready debug stream. A load
//            latches the beat tags and raises valid; the data word is taken
//            from data_i during the first offered cycle (covering a one-cycle
//            read latency upstream) and held from then on until the next
//            load. All fields stay stable while valid && !ready.
// Revision : 1.0 - initial release
// ============================================================================
module dump_beat_reg #(
  parameter int DW = 32,
  parameter int CW = 1,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] chan_i,
  input  logic [IW-1:0] idx_i,
  input  logic          last_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [CW-1:0] chan_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic          fresh_q, fresh_d;
  logic [CW-1:0] chan_q,  chan_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          last_q,  last_d;
  logic [DW-1:0] data_q,  data_d;

  // Next beat state: capture data on the fresh cycle, drop valid on accept,
  // and let a new load override both.
  always_comb begin
    valid_d = valid_q;
    fresh_d = 1'b0;
    chan_d  = chan_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    if (fresh_q) begin
      data_d = data_i;
    end
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      fresh_d = 1'b1;
      chan_d  = chan_i;
      idx_d   = idx_i;
      last_d  = last_i;
    end
  end

  // Beat holding flops
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      chan_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      chan_q  <= chan_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign chan_o  = chan_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign data_o  = fresh_q ? data_i : data_q;

endmodule
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_ctrl
// Brief    : End-of-run register-file dump engine. Counts run cycles after
//            start; on halt request or budget expiry it freezes the core and
//            streams every register of every channel (chan-major, idx-minor)
//            over a valid/ready interface, one beat per two cycles.
//            Optional macro REGFILE_DUMP_CHECKSUM_EN appends one checksum
//            beat (acc = rol(acc,1) ^ data) after the last register.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NCHAN = 2,
  parameter int CYC_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CYC_W-1:0]    cyc_budget,
  input  logic                halt_req,
  output logic                core_freeze,
  output logic [CYC_W-1:0]    run_cycles,
  output logic                busy,
  output logic                done,
  regfile_dump_ctrl_if.master dump
);

  localparam int CW = cw_f(NCHAN);
  localparam int IW = iw_f(NREGS);
  localparam logic [CW-1:0] C_LAST_CHAN = CW'(NCHAN - 1);
  localparam logic [IW-1:0] C_LAST_IDX  = IW'(NREGS - 1);

  dump_state_e      state_q,       state_d;
  logic [CYC_W-1:0] run_cycles_q,  run_cycles_d;
  logic [CYC_W-1:0] budget_q,      budget_d;
  logic [CW-1:0]    chan_q,        chan_d;
  logic [IW-1:0]    idx_q,         idx_d;
  logic [CW-1:0]    dbg_rchan_q,   dbg_rchan_d;
  logic [IW-1:0]    dbg_raddr_q,   dbg_raddr_d;
  logic             core_freeze_q, core_freeze_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;

  logic             w_run_sat;
  logic             w_budget_hit;
  logic             w_final_reg;
  logic             w_handshake;
  logic             w_beat_load;
  logic [CW-1:0]    w_beat_chan;
  logic [IW-1:0]    w_beat_idx;
  logic             w_beat_last;
  logic [XLEN-1:0]  w_beat_data;
  logic             w_dump_valid;
  logic [CW-1:0]    w_dump_chan;
  logic [IW-1:0]    w_dump_idx;
  logic             w_dump_last;
  logic [XLEN-1:0]  w_dump_data;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]  acc_q, acc_d;
  logic             csum_q, csum_d;
  logic             w_csum_load;
`endif

  assign w_run_sat    = &run_cycles_q;
  // Wider compare so a saturated counter can never alias onto the budget.
  assign w_budget_hit = (budget_q != '0) &&
                        (({1'b0, run_cycles_q} + (CYC_W + 1)'(1)) == {1'b0, budget_q});
  assign w_final_reg  = (chan_q == C_LAST_CHAN) && (idx_q == C_LAST_IDX);
  assign w_handshake  = w_dump_valid && dump.dump_ready;

  // Sequencer next state, counters, checksum and registered status outputs
  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    budget_d     = budget_q;
    chan_d       = chan_q;
    idx_d        = idx_q;
    w_beat_load  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d        = acc_q;
    csum_d       = csum_q;
    w_csum_load  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          budget_d     = cyc_budget;
          run_cycles_d = '0;
        end
      end
      S_RUN: begin
        if (!w_run_sat) begin
          run_cycles_d = run_cycles_q + CYC_W'(1);
        end
        // Halt and budget expiry on the same cycle share this single exit.
        if (halt_req || w_budget_hit) begin
          state_d = S_RD;
          chan_d  = '0;
          idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
          csum_d  = 1'b0;
`endif
        end
      end
      S_RD: begin
        state_d     = S_SEND;
        w_beat_load = 1'b1;
      end
      S_SEND: begin
        if (w_handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          if (!csum_q) begin
            acc_d = XLEN'(rol1(ROL_MAX_W'(acc_q), XLEN)) ^ w_dump_data;
          end
`endif
          if (w_dump_last) begin
            state_d = S_DONE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          end else if (w_final_reg) begin
            // Checksum beat follows directly; acc is already final next cycle.
            w_beat_load = 1'b1;
            w_csum_load = 1'b1;
            csum_d      = 1'b1;
`endif
          end else begin
            state_d = S_RD;
            if (idx_q == C_LAST_IDX) begin
              idx_d  = '0;
              chan_d = chan_q + CW'(1);
            end else begin
              idx_d  = idx_q + IW'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read address changes only on entry to RD and is held everywhere else.
    dbg_rchan_d = dbg_rchan_q;
    dbg_raddr_d = dbg_raddr_q;
    if (state_d == S_RD) begin
      dbg_rchan_d = chan_d;
      dbg_raddr_d = idx_d;
    end
    core_freeze_d = (state_d == S_RD) || (state_d == S_SEND) || (state_d == S_DONE);
    busy_d        = (state_d == S_RUN) || (state_d == S_RD) || (state_d == S_SEND);
    done_d        = (state_d == S_DONE);
  end

  // Sequencer and status flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      run_cycles_q  <= '0;
      budget_q      <= '0;
      chan_q        <= '0;
      idx_q         <= '0;
      dbg_rchan_q   <= '0;
      dbg_raddr_q   <= '0;
      core_freeze_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q         <= '0;
      csum_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      run_cycles_q  <= run_cycles_d;
      budget_q      <= budget_d;
      chan_q        <= chan_d;
      idx_q         <= idx_d;
      dbg_rchan_q   <= dbg_rchan_d;
      dbg_raddr_q   <= dbg_raddr_d;
      core_freeze_q <= core_freeze_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q         <= acc_d;
      csum_q        <= csum_d;
`endif
    end
  end

  // Tags and data source of the beat about to be loaded
  always_comb begin
    w_beat_chan = chan_q;
    w_beat_idx  = idx_q;
    w_beat_last = w_final_reg;
    w_beat_data = dump.dbg_rdata;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    w_beat_last = 1'b0;
    if (w_csum_load) begin
      w_beat_chan = '0;
      w_beat_idx  = '0;
      w_beat_last = 1'b1;
    end
    if (csum_q) begin
      w_beat_data = acc_q;
    end
`endif
  end

  dump_beat_reg #(
    .DW (XLEN),
    .CW (CW),
    .IW (IW)
  ) u_beat (
    .clk     (clk),
    .reset   (reset),
    .load    (w_beat_load),
    .chan_i  (w_beat_chan),
    .idx_i   (w_beat_idx),
    .last_i  (w_beat_last),
    .data_i  (w_beat_data),
    .ready_i (dump.dump_ready),
    .valid_o (w_dump_valid),
    .chan_o  (w_dump_chan),
    .idx_o   (w_dump_idx),
    .last_o  (w_dump_last),
    .data_o  (w_dump_data)
  );

  assign dump.dbg_rchan  = dbg_rchan_q;
  assign dump.dbg_raddr  = dbg_raddr_q;
  assign dump.dump_valid = w_dump_valid;
  assign dump.dump_data  = w_dump_data;
  assign dump.dump_chan  = w_dump_chan;
  assign dump.dump_idx   = w_dump_idx;
  assign dump.dump_last  = w_dump_last;

  assign core_freeze = core_freeze_q;
  assign run_cycles  = run_cycles_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Parametrised end-of-run register-file dump engine for the pipelined RISC-V cores (integer and FP register files).
- Counts run cycles after start. On halt request or cycle budget expiry, it freezes the core and streams every register of every channel over a valid/ready interface.
- Replaces fixed-delay bench dumps with a deterministic, cycle-accurate, reusable dump unit.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, registers per channel (>=2).
- NCHAN, 2, number of register files (0 = integer, 1 = FP).
- CYC_W, 32, width of cycle counter and budget.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins run phase (accepted in IDLE or DONE only).
- cyc_budget  in  CYC_W  max run cycles; sampled on accepted start; 0 means no limit.
- halt_req  in  1  core halt (ebreak/ecall); level, sampled in RUN only.
- core_freeze  out  1  stalls core while dumping or done.
- dbg_rchan  out  CW=max(1,$clog2(NCHAN))  debug read channel select.
- dbg_raddr  out  IW=$clog2(NREGS)  debug read index.
- dbg_rdata  in  XLEN  debug read data; synchronous, 1-cycle latency.
- dump_valid  out  1  beat valid.
- dump_ready  in  1  sink ready.
- dump_data  out  XLEN  register value.
- dump_chan  out  CW  channel of beat.
- dump_idx  out  IW  index of beat.
- dump_last  out  1  final beat of dump.
- run_cycles  out  CYC_W  cycles spent in RUN, frozen at halt.
- busy  out  1  state != IDLE and != DONE.
- done  out  1  dump complete; held until next start or reset.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; counters and indices 0. Reset mid-dump aborts at that edge; the partial dump is discarded.
- IDLE: on start, latch cyc_budget, clear run_cycles, go to RUN.
- RUN: run_cycles increments every cycle.
  - Exit on halt_req=1, or on budget!=0 with run_cycles+1==budget.
  - On exit: go to RD; chan=0, idx=0; core_freeze=1 from the next cycle.
  - Simultaneous halt_req and budget hit: a single exit.
  - run_cycles saturates at all-ones.
- RD: drive dbg_rchan/dbg_raddr; next state SEND.
- SEND:
  - At entry, dump_data captures dbg_rdata; chan/idx/last are registered; dump_valid=1.
  - Beat fields are held stable while valid && !ready.
  - On handshake:
    - If last, go to DONE with valid=0.
    - Otherwise, if idx==NREGS-1 then idx=0 and chan++; else idx++. Go to RD.
- Order: chan-major, idx-minor. Total beats = NCHAN*NREGS.
- dump_last=1 only on chan=NCHAN-1, idx=NREGS-1.
- Throughput: 1 beat per 2 cycles with ready held high.
- DONE: done=1, core_freeze=1. start re-enters RUN; done clears on the next edge.
- start in RUN/RD/SEND is ignored. halt_req outside RUN is ignored.
- dbg_* outputs hold their last value outside RD.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- When defined: a running XOR of all dumped values, plus a rotate-left-1 of the accumulator per beat, is emitted as one extra beat after the last register.
  - Fields of the extra beat: chan=0, idx=0.
  - dump_last moves to this checksum beat; total beats = NCHAN*NREGS+1.
  - Formula: acc = rol(acc,1) ^ data; acc=0 at dump start.
- When undefined: no checksum logic; behaviour exactly as above.

Decomposition:
- Package regfile_dump_pkg: state enum (IDLE, RUN, RD, SEND, DONE), CW/IW width functions, checksum rol function.
- Sub-module dump_beat_reg: output holding register with valid/ready stall. It is natural to reuse it for other debug streams.

Test Plan:
- NREGS=4, NCHAN=2; rf0[i]=0x10+i, rf1[i]=0x20+i; start, budget=10, ready=1 -> run_cycles=10; 8 beats in order 0x10..0x13, 0x20..0x23; last on beat 8; done=1.
- budget=0, halt_req at run cycle 5 -> run_cycles=5; freeze asserts the next cycle; same 8 beats.
- ready toggled 1,0,0,1 -> beat fields stable while stalled; no beat lost or duplicated; idx/chan sequence unchanged.
- halt_req coincident with budget expiry (budget=7, halt at cycle 7) -> single exit; run_cycles=7; exactly 8 beats.
- reset asserted during beat 3 -> next edge IDLE, valid=0, done=0. A new start dumps from chan 0, idx 0.
- With REGFILE_DUMP_CHECKSUM_EN: same data -> 9th beat carries computed acc; last only on 9th; start in DONE restarts cleanly.
